move_history: RTL
=================

Name: move_history

Overview:
- LIFO record of every stone placed on the 15x15 Gobang board.
- Sits directly upstream of the round counter and the board-state memory:
  - accepts placement requests from the game controller;
  - issues the write/write_color/retract strobes the round counter edge-detects;
  - drives board-memory writes for placement and for undo (retract), using the stored move history.
- Also exports last-move coordinates for cursor/highlight rendering.

Parameters:
- DEPTH, 225, maximum stored moves (15x15 board).
- COORD_W, 4, width of x/y coordinate.
- PTR_W, 8, stack pointer / count width; must satisfy 2^PTR_W > DEPTH.

Ports:
- clk  in  1  system clock, 25 MHz.
- rst_p  in  1  reset; asynchronous, active-high.
- place_valid  in  1  single-cycle placement request.
- place_x  in  COORD_W  column of stone, valid with place_valid.
- place_y  in  COORD_W  row of stone, valid with place_valid.
- place_color  in  1  0 = black, 1 = white.
- retract_req  in  1  undo request, level; rising edge detected internally.
- clr  in  1  synchronous clear of history (new game).
- write  out  1  one-cycle placement strobe to round counter.
- write_color  out  1  colour of the stone just placed or just removed; held between events.
- retract  out  1  one-cycle undo strobe to round counter.
- board_we  out  1  board-memory write enable.
- board_x  out  COORD_W  board write column.
- board_y  out  COORD_W  board write row.
- board_data  out  2  00 empty, 01 black, 10 white.
- count  out  PTR_W  moves currently stored.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- busy  out  1  FSM not in IDLE.
- last_valid  out  1  last_x/last_y/last_color meaningful.
- last_x  out  COORD_W  coordinate of top-of-stack move.
- last_y  out  COORD_W  coordinate of top-of-stack move.
- last_color  out  1  colour of top-of-stack move.
- drop  out  1  one-cycle pulse: request discarded (place while full, or place/retract while busy).

Behaviour:
- Reset: every output 0; FSM = IDLE; stack pointer 0; retract edge register 0. RAM contents are don't-care.
- Storage: synchronous-read RAM, DEPTH x (2*COORD_W+1), one-cycle read latency. Entry = {color, y, x}.
- FSM states: IDLE, PUSH, RD, ERASE, REFRESH. All outputs are registered.
- Placement (accepted only in IDLE and when not full), place_valid sampled at cycle T:
  - T+1: state PUSH; write=1; write_color=place_color; board_we=1; board_x/y=place coords; board_data=color+1; count+1; last_* = placed move; last_valid=1.
  - T+2: IDLE; write=0; board_we=0.
  - This guarantees write returns low for at least one cycle between consecutive placements, so every placement produces a distinct rising edge.
- Retract (rising edge of retract_req in IDLE with count>0), edge at cycle T:
  - T+1: RD, read address count-1.
  - T+2: ERASE; retract=1; write_color=popped color; board_we=1; board_x/y=popped coords; board_data=00; count-1.
  - T+3: REFRESH; read new top (address count-1) if count>0.
  - T+4: IDLE; last_* = new top, or last_valid=0 and last_* = 0 if empty.
  - write_color reflects the removed stone, so the round counter decrements only when a black stone is undone.
- Place while full: ignored, drop=1 for one cycle.
- Retract while empty: ignored silently, no strobe.
- Any request while busy: ignored; drop=1 for one cycle. A retract edge arriving while busy is consumed, not queued.
- place_valid and a retract edge in the same IDLE cycle: placement wins; retract discarded with drop=1.
- clr: highest priority in every state.
  - Next cycle: IDLE, count=0, last_valid=0, all strobes 0.
  - Board memory is not erased by this block; the board clears on clr itself.
- rst_p mid-operation (any state): immediate return to reset values; a partially issued strobe is truncated.
- Coordinates are not range-checked; the controller guarantees 0..14.

Decomposition:
- Shared package gobang_pkg:
  - BOARD_N=15, COORD_W=4;
  - stone encoding constants EMPTY=2'b00, BLACK=2'b01, WHITE=2'b10;
  - FSM state typedef.
- One natural sub-module: move_ram, a simple dual-port synchronous RAM (1 write port, 1 read port, registered read).

Test Plan:
- Reset, then place black (3,4) → T+1: write=1, write_color=0, board_we=1, board_data=01, board_x=3, board_y=4, count=1, last=(3,4,0); T+2: write=0.
- Place black (3,4) then white (5,5) on back-to-back IDLE opportunities → two separate write pulses with write low between them, count=2, last=(5,5,1).
- From that state, raise retract_req → T+2: retract=1, write_color=1, board erase at (5,5), count=1; T+4: last=(3,4,0). Retract again → write_color=0, count=0, empty=1, last_valid=0.
- Retract with count=0 → no retract pulse, no board_we, count stays 0.
- Fill 225 moves, then place another → drop=1, full=1, count=225, no write.
- Assert clr during ERASE → next cycle IDLE, count=0, retract=0, board_we=0.
- Assert rst_p during RD → all outputs 0 immediately.

Source files
------------

// File: rtl/gobang_pkg.sv
// Shared Gobang board constants, stone encoding, move-history FSM states and the stored move record.
package gobang_pkg;

    localparam int unsigned BOARD_N    = 15;
    localparam int unsigned COORD_W    = 4;
    localparam int unsigned MOVE_DEPTH = BOARD_N * BOARD_N;
    localparam int unsigned MOVE_PTR_W = 8;
    localparam int unsigned MOVE_W     = 2 * COORD_W + 1;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] BLACK = 2'b01;
    localparam logic [1:0] WHITE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH,
        ST_RD,
        ST_ERASE,
        ST_REFRESH
    } state_e;

    typedef struct packed {
        logic               color;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } move_t;

    function automatic logic [1:0] stone_code(input logic color);
        return color ? WHITE : BLACK;
    endfunction

endpackage

// File: rtl/move_ram.sv
// Simple dual-port RAM: one write port, one registered read port (one-cycle read latency).
module move_ram #(
    parameter int unsigned DEPTH  = 225,
    parameter int unsigned WIDTH  = 9,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/move_history.sv
// LIFO of placed stones: issues round-counter strobes and board-memory writes for place and undo,
// and exports the top-of-stack move for cursor highlighting.
module move_history
    import gobang_pkg::*;
#(
    parameter int unsigned DEPTH = MOVE_DEPTH,
    parameter int unsigned PTR_W = MOVE_PTR_W
) (
    input  logic               clk,
    input  logic               rst_p,
    input  logic               place_valid,
    input  logic [COORD_W-1:0] place_x,
    input  logic [COORD_W-1:0] place_y,
    input  logic               place_color,
    input  logic               retract_req,
    input  logic               clr,
    output logic               write,
    output logic               write_color,
    output logic               retract,
    output logic               board_we,
    output logic [COORD_W-1:0] board_x,
    output logic [COORD_W-1:0] board_y,
    output logic [1:0]         board_data,
    output logic [PTR_W-1:0]   count,
    output logic               empty,
    output logic               full,
    output logic               busy,
    output logic               last_valid,
    output logic [COORD_W-1:0] last_x,
    output logic [COORD_W-1:0] last_y,
    output logic               last_color,
    output logic               drop
);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   count_q, count_d;
    logic               retract_req_q, retract_req_d;
    logic               write_q, write_d;
    logic               write_color_q, write_color_d;
    logic               retract_q, retract_d;
    logic               board_we_q, board_we_d;
    logic [COORD_W-1:0] board_x_q, board_x_d;
    logic [COORD_W-1:0] board_y_q, board_y_d;
    logic [1:0]         board_data_q, board_data_d;
    logic               empty_q, empty_d;
    logic               full_q, full_d;
    logic               busy_q, busy_d;
    logic               last_valid_q, last_valid_d;
    logic [COORD_W-1:0] last_x_q, last_x_d;
    logic [COORD_W-1:0] last_y_q, last_y_d;
    logic               last_color_q, last_color_d;
    logic               drop_q, drop_d;

    logic               retract_edge;
    logic               ram_we;
    move_t              wr_move;
    move_t              rd_move;
    logic [PTR_W-1:0]   rd_addr;

    // Read address always tracks the current top so the entry is ready one cycle later.
    assign rd_addr      = (count_q == '0) ? '0 : count_q - PTR_W'(1);
    assign retract_edge = retract_req & ~retract_req_q;

    move_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (MOVE_W),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (count_q),
        .wr_data (wr_move),
        .rd_addr (rd_addr),
        .rd_data (rd_move)
    );

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        retract_req_d = retract_req;
        write_d       = 1'b0;
        retract_d     = 1'b0;
        board_we_d    = 1'b0;
        drop_d        = 1'b0;
        write_color_d = write_color_q;
        board_x_d     = board_x_q;
        board_y_d     = board_y_q;
        board_data_d  = board_data_q;
        last_valid_d  = last_valid_q;
        last_x_d      = last_x_q;
        last_y_d      = last_y_q;
        last_color_d  = last_color_q;
        ram_we        = 1'b0;
        wr_move       = '{color: place_color, y: place_y, x: place_x};

        if (clr) begin
            state_d      = ST_IDLE;
            count_d      = '0;
            last_valid_d = 1'b0;
            last_x_d     = '0;
            last_y_d     = '0;
            last_color_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (place_valid) begin
                        // Placement wins over a simultaneous retract edge.
                        drop_d = retract_edge;
                        if (count_q == PTR_W'(DEPTH)) begin
                            drop_d = 1'b1;
                        end else begin
                            ram_we        = 1'b1;
                            state_d       = ST_PUSH;
                            write_d       = 1'b1;
                            write_color_d = place_color;
                            board_we_d    = 1'b1;
                            board_x_d     = place_x;
                            board_y_d     = place_y;
                            board_data_d  = stone_code(place_color);
                            count_d       = count_q + PTR_W'(1);
                            last_valid_d  = 1'b1;
                            last_x_d      = place_x;
                            last_y_d      = place_y;
                            last_color_d  = place_color;
                        end
                    end else if (retract_edge && (count_q != '0)) begin
                        state_d = ST_RD;
                    end
                end
                ST_PUSH: begin
                    state_d = ST_IDLE;
                    drop_d  = place_valid | retract_edge;
                end
                ST_RD: begin
                    state_d       = ST_ERASE;
                    drop_d        = place_valid | retract_edge;
                    retract_d     = 1'b1;
                    write_color_d = rd_move.color;
                    board_we_d    = 1'b1;
                    board_x_d     = rd_move.x;
                    board_y_d     = rd_move.y;
                    board_data_d  = EMPTY;
                    count_d       = count_q - PTR_W'(1);
                end
                ST_ERASE: begin
                    state_d = ST_REFRESH;
                    drop_d  = place_valid | retract_edge;
                end
                ST_REFRESH: begin
                    state_d = ST_IDLE;
                    drop_d  = place_valid | retract_edge;
                    if (count_q != '0) begin
                        last_valid_d = 1'b1;
                        last_x_d     = rd_move.x;
                        last_y_d     = rd_move.y;
                        last_color_d = rd_move.color;
                    end else begin
                        last_valid_d = 1'b0;
                        last_x_d     = '0;
                        last_y_d     = '0;
                        last_color_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == PTR_W'(DEPTH));
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            retract_req_q <= 1'b0;
            write_q       <= 1'b0;
            write_color_q <= 1'b0;
            retract_q     <= 1'b0;
            board_we_q    <= 1'b0;
            board_x_q     <= '0;
            board_y_q     <= '0;
            board_data_q  <= '0;
            empty_q       <= 1'b0;
            full_q        <= 1'b0;
            busy_q        <= 1'b0;
            last_valid_q  <= 1'b0;
            last_x_q      <= '0;
            last_y_q      <= '0;
            last_color_q  <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            retract_req_q <= retract_req_d;
            write_q       <= write_d;
            write_color_q <= write_color_d;
            retract_q     <= retract_d;
            board_we_q    <= board_we_d;
            board_x_q     <= board_x_d;
            board_y_q     <= board_y_d;
            board_data_q  <= board_data_d;
            empty_q       <= empty_d;
            full_q        <= full_d;
            busy_q        <= busy_d;
            last_valid_q  <= last_valid_d;
            last_x_q      <= last_x_d;
            last_y_q      <= last_y_d;
            last_color_q  <= last_color_d;
            drop_q        <= drop_d;
        end
    end

    assign write       = write_q;
    assign write_color = write_color_q;
    assign retract     = retract_q;
    assign board_we    = board_we_q;
    assign board_x     = board_x_q;
    assign board_y     = board_y_q;
    assign board_data  = board_data_q;
    assign count       = count_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign busy        = busy_q;
    assign last_valid  = last_valid_q;
    assign last_x      = last_x_q;
    assign last_y      = last_y_q;
    assign last_color  = last_color_q;
    assign drop        = drop_q;

endmodule
